// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity-select codes and
// data-length decode used by both the transmit and receive paths.
package uart_pkg;

    // State encoding is shared with the receiver, so values are fixed.
    typedef enum logic [2:0] {
        StIdle     = 3'b000,
        StStart    = 3'b001,
        StTransmit = 3'b010,
        StParity   = 3'b011,
        StStopI    = 3'b100,
        StStopII   = 3'b101
    } uart_state_e;

    // Parity-select codes; any code with bit 2 clear means no parity bit.
    localparam logic [2:0] NON_PARITY  = 3'b000;
    localparam logic [2:0] EVEN_PARITY = 3'b100;
    localparam logic [2:0] ODD_PARITY  = 3'b101;
    localparam logic [2:0] ZERO_STICK  = 3'b110;
    localparam logic [2:0] ONE_STICK   = 3'b111;

    // Character length code to number of data bits: 00=5 ... 11=8.
    function automatic logic [3:0] data_bits(input logic [1:0] len);
        return 4'd5 + {2'b00, len};
    endfunction

endpackage

// File: rtl/uart_tx_parity_gen.sv
// Transmit-side parity generator: accumulates the XOR of sent data bits and
// produces the even/odd/stick parity bit selected by the latched line control.
module tx_parity_gen
    import uart_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_clr,
    input  logic       i_en,
    input  logic       i_bit,
    input  logic [2:0] i_sel,
    output logic       o_parity
);

    logic acc_q;

    // Running XOR of the data bits placed on the line.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_q <= 1'b0;
        end else if (i_clr) begin
            acc_q <= 1'b0;
        end else if (i_en) begin
            acc_q <= acc_q ^ i_bit;
        end
    end

    // Stick codes force a constant; odd inverts the accumulated even parity.
    always_comb begin
        o_parity = acc_q;
        case (i_sel)
            ZERO_STICK:  o_parity = 1'b0;
            ONE_STICK:   o_parity = 1'b1;
            ODD_PARITY:  o_parity = ~acc_q;
            EVEN_PARITY: o_parity = acc_q;
            default:     o_parity = acc_q ^ i_sel[0];
        endcase
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmit engine: serialises one 5-8 bit character into a
// start/data/parity/stop frame, timed by an oversampled baud tick.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_W     = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_baud,
    input  logic              i_tx_valid,
    input  logic [DATA_W-1:0] i_tx_data,
    input  logic [1:0]        i_data_len,
    input  logic              i_stop_sel,
    input  logic [2:0]        i_parity_sel,
    output logic              o_tx_ready,
    output logic              o_tx_out,
    output logic              o_busy,
    output logic              o_tx_done
);

    localparam int unsigned    CntW   = $clog2(OVERSAMPLE);
    localparam logic [CntW-1:0] CntMax = CntW'(OVERSAMPLE - 1);

    uart_state_e       state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [1:0]        len_q, len_d;
    logic              stop_q, stop_d;
    logic [2:0]        par_q, par_d;
    logic              tx_q, tx_d;
    logic              done_q, done_d;

    logic is_idle;
    logic accept;
    logic bit_end;
    logic last_bit;
    logic par_clr;
    logic par_en;
    logic parity_bit;

    assign is_idle  = (state_q == StIdle);
    assign accept   = is_idle & i_tx_valid;
    assign bit_end  = i_baud & (cnt_q == CntMax);
    assign last_bit = (bit_cnt_q == 3'(data_bits(len_q) - 4'd1));

    assign o_tx_ready = is_idle;
    assign o_busy     = ~is_idle;
    assign o_tx_out   = tx_q;
    assign o_tx_done  = done_q;

    tx_parity_gen u_parity (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_clr    (par_clr),
        .i_en     (par_en),
        .i_bit    (shift_q[0]),
        .i_sel    (par_q),
        .o_parity (parity_bit)
    );

    // Oversample tick counter; held at zero in IDLE so a tick coinciding
    // with acceptance is not credited to the start bit.
    always_comb begin
        cnt_d = cnt_q;
        if (is_idle || accept) begin
            cnt_d = '0;
        end else if (i_baud) begin
            cnt_d = bit_end ? '0 : cnt_q + CntW'(1);
        end
    end

    // Frame sequencing, line-control latching and data shifting.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        len_d     = len_q;
        stop_d    = stop_q;
        par_d     = par_q;
        done_d    = 1'b0;
        par_clr   = 1'b0;
        par_en    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_tx_valid) begin
                    shift_d = i_tx_data;
                    len_d   = i_data_len;
                    stop_d  = i_stop_sel;
                    par_d   = i_parity_sel;
                    state_d = StStart;
                end
            end
            StStart: begin
                par_clr = 1'b1;
                if (bit_end) begin
                    bit_cnt_d = '0;
                    state_d   = StTransmit;
                end
            end
            StTransmit: begin
                if (bit_end) begin
                    shift_d   = {1'b0, shift_q[DATA_W-1:1]};
                    par_en    = 1'b1;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (last_bit) begin
                        state_d = par_q[2] ? StParity : StStopI;
                    end
                end
            end
            StParity: begin
                if (bit_end) begin
                    state_d = StStopI;
                end
            end
            StStopI: begin
                if (bit_end) begin
                    if (stop_q) begin
                        state_d = StStopII;
                    end else begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
            end
            StStopII: begin
                if (bit_end) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Line level for the current state; registered so the pin never glitches.
    always_comb begin
        tx_d = 1'b1;
        case (state_q)
            StStart:    tx_d = 1'b0;
            StTransmit: tx_d = shift_q[0];
            StParity:   tx_d = parity_bit;
            default:    tx_d = 1'b1;
        endcase
    end

    // State registers; reset drives the line high without passing through 0.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            len_q     <= '0;
            stop_q    <= 1'b0;
            par_q     <= NON_PARITY;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            len_q     <= len_d;
            stop_q    <= stop_d;
            par_q     <= par_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: expected line bits and frame tick counts
// are queued when a character is offered and compared as the frame appears.
module tb_uart_tx;

    localparam int OS       = 16;
    localparam int BAUD_DIV = 4;
    localparam int BIT_CLKS = OS * BAUD_DIV;

    logic       i_clk        = 1'b0;
    logic       i_rst_n      = 1'b0;
    logic       i_baud       = 1'b0;
    logic       i_tx_valid   = 1'b0;
    logic [7:0] i_tx_data    = 8'h00;
    logic [1:0] i_data_len   = 2'b11;
    logic       i_stop_sel   = 1'b0;
    logic [2:0] i_parity_sel = 3'b000;
    logic       o_tx_ready;
    logic       o_tx_out;
    logic       o_busy;
    logic       o_tx_done;

    int   checks = 0;
    int   passes = 0;
    bit   mon_en = 1'b1;
    logic exp_bit_q[$];
    int   exp_len_q[$];
    int   exp_tick_q[$];

    uart_tx #(
        .OVERSAMPLE (OS),
        .DATA_W     (8)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_baud       (i_baud),
        .i_tx_valid   (i_tx_valid),
        .i_tx_data    (i_tx_data),
        .i_data_len   (i_data_len),
        .i_stop_sel   (i_stop_sel),
        .i_parity_sel (i_parity_sel),
        .o_tx_ready   (o_tx_ready),
        .o_tx_out     (o_tx_out),
        .o_busy       (o_busy),
        .o_tx_done    (o_tx_done)
    );

    always #5 i_clk = ~i_clk;

    // One-clock baud tick every BAUD_DIV clocks, free running.
    initial begin : baud_gen
        forever begin
            repeat (BAUD_DIV - 1) @(posedge i_clk);
            #1 i_baud = 1'b1;
            @(posedge i_clk);
            #1 i_baud = 1'b0;
        end
    end

    // Line monitor: on a start edge, sample every bit at its midpoint.
    initial begin : bit_mon
        int   len;
        logic want;
        forever begin
            @(negedge i_clk);
            if (mon_en && i_rst_n && o_tx_out === 1'b0) begin
                if (exp_len_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_frame: line low at %0t, no frame expected", $time);
                    repeat (12 * BIT_CLKS) @(negedge i_clk);
                end else begin
                    len = exp_len_q.pop_front();
                    repeat (BIT_CLKS / 2 - 1) @(negedge i_clk);
                    for (int i = 0; i < len; i++) begin
                        want = exp_bit_q.pop_front();
                        checks++;
                        if (o_tx_out !== want)
                            $display("FAIL frame_bit[%0d]: o_tx_out=%b expected %b at %0t",
                                     i, o_tx_out, want, $time);
                        else passes++;
                        if (i != len - 1) repeat (BIT_CLKS) @(negedge i_clk);
                    end
                end
            end
        end
    end

    // Frame-length monitor: baud ticks consumed while busy, checked at done.
    initial begin : tick_mon
        int ticks;
        int want;
        ticks = 0;
        forever begin
            @(negedge i_clk);
            if (!i_rst_n) begin
                ticks = 0;
            end else begin
                if (o_busy && i_baud) ticks++;
                if (o_tx_done) begin
                    checks++;
                    if (exp_tick_q.size() == 0) begin
                        $display("FAIL unexpected_done: o_tx_done=1 expected 0 at %0t", $time);
                    end else begin
                        want = exp_tick_q.pop_front();
                        if (ticks != want)
                            $display("FAIL frame_ticks: got %0d ticks expected %0d", ticks, want);
                        else passes++;
                    end
                    ticks = 0;
                end
            end
        end
    end

    initial begin : watchdog
        repeat (90000) @(posedge i_clk);
        $display("FAIL watchdog: simulation did not finish within 90000 cycles");
        $fatal(1, "watchdog expired");
    end

    // Reference frame model: start, N data bits LSB first, optional parity, stops.
    task automatic push_expect(input logic [7:0] data, input logic [1:0] len,
                               input logic stop, input logic [2:0] par);
        int   n;
        int   frame;
        logic acc;
        n   = 5 + int'(len);
        acc = 1'b0;
        exp_bit_q.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            exp_bit_q.push_back(data[i]);
            acc ^= data[i];
        end
        frame = 2 + n;
        if (par[2]) begin
            exp_bit_q.push_back(par[1] ? par[0] : (acc ^ par[0]));
            frame++;
        end
        exp_bit_q.push_back(1'b1);
        if (stop) begin
            exp_bit_q.push_back(1'b1);
            frame++;
        end
        exp_len_q.push_back(frame);
        exp_tick_q.push_back(frame * OS);
    endtask

    task automatic send(input logic [7:0] data, input logic [1:0] len, input logic stop,
                        input logic [2:0] par, input bit expect_it);
        bit ok;
        if (expect_it) push_expect(data, len, stop, par);
        @(posedge i_clk);
        #1;
        i_tx_valid   = 1'b1;
        i_tx_data    = data;
        i_data_len   = len;
        i_stop_sel   = stop;
        i_parity_sel = par;
        ok = 1'b0;
        for (int i = 0; i < 4000 && !ok; i++) begin
            @(negedge i_clk);
            if (o_tx_ready) ok = 1'b1;
        end
        @(posedge i_clk);
        #1 i_tx_valid = 1'b0;
        if (!ok) begin
            checks++;
            $display("FAIL send_handshake: o_tx_ready=0 expected 1 within 4000 cycles");
        end
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20000 && !seen; i++) begin
            @(negedge i_clk);
            if (o_tx_done) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            $display("FAIL %s_done_timeout: o_tx_done=0 expected 1 within 20000 cycles", name);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge i_clk);
        checks++; if (o_tx_out !== 1'b1) $display("FAIL reset_tx_out: got %b want 1", o_tx_out);
        else passes++;
        checks++; if (o_tx_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", o_tx_ready);
        else passes++;
        checks++; if (o_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", o_busy);
        else passes++;
        checks++; if (o_tx_done !== 1'b0) $display("FAIL reset_done: got %b want 0", o_tx_done);
        else passes++;
        @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        repeat (5) @(negedge i_clk);
        checks++; if (o_tx_out !== 1'b1) $display("FAIL idle_tx_out: got %b want 1", o_tx_out);
        else passes++;
    endtask

    task automatic test_8n1();
        send(8'hA5, 2'b11, 1'b0, 3'b000, 1'b1);
        wait_done("8n1");
        checks++; if (o_tx_ready !== 1'b1) $display("FAIL done_ready: got %b want 1", o_tx_ready);
        else passes++;
        @(negedge i_clk);
        checks++; if (o_tx_done !== 1'b0) $display("FAIL done_width: got %b want 0", o_tx_done);
        else passes++;
        repeat (2 * BIT_CLKS) @(negedge i_clk);
        checks++; if (o_tx_out !== 1'b1) $display("FAIL post_idle_line: got %b want 1", o_tx_out);
        else passes++;
        checks++; if (o_busy !== 1'b0) $display("FAIL post_idle_busy: got %b want 0", o_busy);
        else passes++;
    endtask

    task automatic test_parity();
        send(8'h55, 2'b10, 1'b0, 3'b100, 1'b1);
        wait_done("7e1");
        send(8'h55, 2'b10, 1'b0, 3'b101, 1'b1);
        wait_done("7o1");
    endtask

    task automatic test_stick();
        logic [2:0] sel [2];
        logic [7:0] dat [2];
        sel[0] = 3'b110;
        sel[1] = 3'b111;
        dat[0] = 8'h00;
        dat[1] = 8'hFF;
        for (int s = 0; s < 2; s++) begin
            for (int d = 0; d < 2; d++) begin
                send(dat[d], 2'b11, 1'b0, sel[s], 1'b1);
                wait_done("stick");
            end
        end
    endtask

    task automatic test_5n2();
        send(8'hFF, 2'b00, 1'b1, 3'b000, 1'b1);
        wait_done("5n2");
    endtask

    task automatic test_back_to_back();
        int dones;
        int gaps;
        int n;
        bit ok;
        push_expect(8'h12, 2'b11, 1'b0, 3'b000);
        push_expect(8'h34, 2'b10, 1'b1, 3'b100);
        @(posedge i_clk);
        #1;
        i_tx_valid   = 1'b1;
        i_tx_data    = 8'h12;
        i_data_len   = 2'b11;
        i_stop_sel   = 1'b0;
        i_parity_sel = 3'b000;
        ok = 1'b0;
        for (int i = 0; i < 4000 && !ok; i++) begin
            @(negedge i_clk);
            if (o_tx_ready) ok = 1'b1;
        end
        @(posedge i_clk);
        #1;
        // Next character and new line control presented while frame 1 runs.
        i_tx_data    = 8'h34;
        i_data_len   = 2'b10;
        i_stop_sel   = 1'b1;
        i_parity_sel = 3'b100;
        dones = 0;
        gaps  = 0;
        n     = 0;
        while (dones < 2 && n < 30000) begin
            @(negedge i_clk);
            n++;
            if (o_tx_done) dones++;
            if (dones < 2 && !o_busy) gaps++;
            if (o_tx_ready && i_tx_valid) begin
                @(posedge i_clk);
                #1 i_tx_valid = 1'b0;
            end
        end
        i_tx_valid = 1'b0;
        checks++; if (dones != 2) $display("FAIL b2b_frames: got %0d done pulses want 2", dones);
        else passes++;
        checks++; if (gaps != 1) $display("FAIL b2b_idle_gap: got %0d idle cycles want 1", gaps);
        else passes++;
        repeat (4 * BIT_CLKS) @(negedge i_clk);
        checks++; if (o_busy !== 1'b0) $display("FAIL b2b_end_busy: got %b want 0", o_busy);
        else passes++;
    endtask

    task automatic test_reset_mid_frame();
        mon_en = 1'b0;
        send(8'h81, 2'b11, 1'b0, 3'b000, 1'b0);
        repeat (3 * BIT_CLKS + 32) @(negedge i_clk);
        checks++; if (o_tx_out !== 1'b0) $display("FAIL mid_frame_line: got %b want 0", o_tx_out);
        else passes++;
        checks++; if (o_busy !== 1'b1) $display("FAIL mid_frame_busy: got %b want 1", o_busy);
        else passes++;
        #1 i_rst_n = 1'b0;
        #1;
        checks++; if (o_tx_out !== 1'b1) $display("FAIL rst_mid_line: got %b want 1", o_tx_out);
        else passes++;
        checks++; if (o_busy !== 1'b0) $display("FAIL rst_mid_busy: got %b want 0", o_busy);
        else passes++;
        checks++; if (o_tx_ready !== 1'b1) $display("FAIL rst_mid_ready: got %b want 1", o_tx_ready);
        else passes++;
        repeat (3) @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        mon_en = 1'b1;
        send(8'h3C, 2'b11, 1'b0, 3'b000, 1'b1);
        wait_done("after_reset");
        repeat (BIT_CLKS) @(negedge i_clk);
    endtask

    initial begin : main
        test_reset();
        test_8n1();
        test_parity();
        test_stick();
        test_5n2();
        test_back_to_back();
        test_reset_mid_frame();
        checks++;
        if (exp_bit_q.size() != 0 || exp_tick_q.size() != 0)
            $display("FAIL scoreboard_drain: %0d bits, %0d frames left, expected 0",
                     exp_bit_q.size(), exp_tick_q.size());
        else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmit engine: serialises one 5–8 bit character into a start/data/parity/stop frame on o_tx_out.
- Shares the 16x-oversampled baud tick (i_baud) and the 3-bit parity-select encoding with the UART receive path.
- Sits between the TX FIFO/register interface (valid/ready) and the serial pin.
- Line-control fields are sampled at character acceptance, so CSR writes mid-frame never corrupt the frame on the line.

Parameters:
- OVERSAMPLE, 16, baud ticks per bit period (power of 2, 8 or 16).
- DATA_W, 8, width of i_tx_data (maximum character length).

Ports:
- i_clk  input  1  system clock.
- i_rst_n  input  1  asynchronous active-low reset.
- i_baud  input  1  one-i_clk-wide oversample tick.
- i_tx_valid  input  1  character available on i_tx_data.
- i_tx_data  input  DATA_W  character, LSB transmitted first.
- i_data_len  input  2  00=5, 01=6, 10=7, 11=8 data bits.
- i_stop_sel  input  1  0=one stop bit, 1=two stop bits.
- i_parity_sel  input  3  000 none, 100 even, 101 odd, 110 stick-0, 111 stick-1; any value with bit2=0 means no parity.
- o_tx_ready  output  1  high only in IDLE; handshake completes on i_tx_valid & o_tx_ready.
- o_tx_out  output  1  serial line, idle high.
- o_busy  output  1  high while state != IDLE.
- o_tx_done  output  1  one-cycle pulse when the last stop bit ends.

Behaviour:
- Reset (async, i_rst_n low): state=IDLE, o_tx_out=1, o_tx_ready=1, o_busy=0, o_tx_done=0. Tick counter, bit counter, shift register and parity accumulator are cleared. Asserting reset mid-frame forces the line high immediately, with no glitch to 0.
- Acceptance: on an i_clk edge with i_tx_valid & o_tx_ready, latch i_tx_data, i_data_len, i_stop_sel and i_parity_sel. Go to START and clear the tick counter. o_tx_ready drops on the next cycle. i_tx_valid outside IDLE is ignored.
- Tick counter: 4-bit (log2 OVERSAMPLE); increments only on i_baud. "bit_end" = i_baud & (counter == OVERSAMPLE-1). The counter wraps to 0 at bit_end.
- FSM, with state encodings shared with the receiver (IDLE 000, START 001, TRANSMIT 010, PARITY 011, STOP_I 100, STOP_II 101):
  - IDLE: o_tx_out=1.
  - START: o_tx_out=0. At bit_end go to TRANSMIT and set bit counter=0.
  - TRANSMIT: o_tx_out=shift[0]. At bit_end shift right, XOR the transmitted bit into the parity accumulator and increment the bit counter. When bit counter == N-1, leave for PARITY if sel[2]=1, else STOP_I.
  - PARITY: o_tx_out = sel[0] when sel[1]=1 (stick parity); otherwise acc ^ sel[0]. At bit_end go to STOP_I.
  - STOP_I: o_tx_out=1. At bit_end go to STOP_II if i_stop_sel latched=1; otherwise go to IDLE and pulse o_tx_done.
  - STOP_II: o_tx_out=1. At bit_end go to IDLE and pulse o_tx_done.
- The parity accumulator clears in START.
- o_tx_out is driven from a register, so it changes one i_clk after the bit_end edge and has no combinational glitches.
- Frame duration: OVERSAMPLE*(1+N+P+S) i_baud ticks, where N is data bits, P is 0 or 1 parity bits and S is 1 or 2 stop bits.
- Back-to-back: o_tx_ready is high in the same cycle IDLE is entered, so a waiting valid is accepted on the next edge. The only gap between frames is one i_clk idle-high cycle; no extra baud period is inserted.
- Unused high data bits (N<8) are never transmitted.
- Acceptance in the same cycle as an i_baud tick: the tick is not counted toward START, so START lasts a full 16 ticks.

Decomposition:
- Package uart_pkg holds:
  - the state localparams/enum (shared with the receive path);
  - parity-select constants NON_PARITY, EVEN_PARITY, ODD_PARITY, ZERO_STICK, ONE_STICK;
  - a data-length decode function (len code to N).
- Sub-module tx_parity_gen (accumulator plus stick/even/odd select) mirrors the receive-side parity checker.
- The FSM, counters and shift register stay in uart_tx.

Test Plan:
- 8N1, data 0xA5, i_baud every 4 clocks: line shows 0, 1,0,1,0,0,1,0,1, 1 over 160 ticks, then o_tx_done pulses once, o_tx_ready returns to 1 and o_tx_out stays 1.
- 7E1 with 0x55 (four ones), then 7O1 with 0x55: parity bit 0 for even, 1 for odd. Frame length is 10 bits (160 ticks).
- Stick parity 110 and 111 with 0x00 and 0xFF, 8 data bits: parity bit is the constant 0 or 1 regardless of data.
- 5 data bits, two stop bits, no parity, data 0xFF: only 5 ones are sent, then 2 stop bits. Total frame is 8 bits (128 ticks), and the upper 3 data bits are never seen on the line.
- Back-to-back valid held high with 0x12 then 0x34; i_tx_data and line-control inputs change mid-frame:
  - exactly two frames are sent, with one idle clock between them;
  - the first frame is unaffected by the input changes;
  - o_busy stays high except that one cycle.
- Reset asserted during TRANSMIT of 0x81: o_tx_out=1, o_busy=0, o_tx_ready=1 immediately. After release, a new 0x3C frame is transmitted correctly from START.
